// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline slice.
// Holds the fetch FSM state encoding and the architectural constants that
// the fetch stage and its neighbours agree on (NOP encoding, reset vector,
// instruction width in bytes).
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ERR  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam int          INSTR_BYTES  = 4;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory bus between the fetch stage and instruction memory.
// Ports (signals):
//   imem_req   - fetch request (fetch -> memory)
//   imem_addr  - byte address of the word to fetch (fetch -> memory)
//   imem_ready - memory accepts the request; data valid same cycle
//   imem_rdata - instruction word returned by memory
// Modports: master = fetch stage side, slave = memory side.
interface fetch_stage_if;
  import mips_pkg::*;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_timeout_ctr.sv
// Wait-cycle counter for an outstanding instruction fetch.
// Ports:
//   clock_pc - clock
//   reset    - asynchronous, active-high
//   inc      - one more cycle spent waiting for imem_ready
//   clr      - restart the count (fetch completed, flushed or idle)
//   hit      - count has reached TIMEOUT-1; the current wait cycle is the last
module fetch_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clock_pc,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic hit
);
  import mips_pkg::*;

  logic [7:0] count_reg;

  always_ff @(posedge clock_pc or posedge reset) begin
    if (reset) begin
      count_reg <= 8'd0;
    end else if (clr) begin
      count_reg <= 8'd0;
    end else if (inc) begin
      count_reg <= count_reg + 8'd1;
    end
  end

  assign hit = (count_reg == 8'(TIMEOUT - 1));

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage sitting right after the PC register.
// Issues a read for the current pc over the imem bus, captures the returned
// word into the IF/ID register and holds the PC (fetch_halt) until the fetch
// completes or a redirect is taken.
// Ports:
//   clock_pc     - clock
//   reset        - asynchronous, active-high
//   pc           - current PC register value
//   flush        - taken branch/jump: drop the fetch in flight and the output
//   decode_stall - decode cannot take instr this cycle
//   imem         - instruction memory bus (master side)
//   instr        - fetched instruction (registered)
//   instr_pc     - address of instr
//   pc_plus4     - instr_pc + 4
//   instr_valid  - instr holds a live instruction
//   fetch_halt   - hold the PC this cycle
//   addr_err     - sticky misaligned-pc fault
//   bus_err      - sticky fetch timeout
module fetch_stage #(
  parameter int          TIMEOUT = 255,
  parameter logic [31:0] NOP     = 32'h0000_0000
) (
  input  logic          clock_pc,
  input  logic          reset,
  input  logic [31:0]   pc,
  input  logic          flush,
  input  logic          decode_stall,
  fetch_stage_if.master imem,
  output logic [31:0]   instr,
  output logic [31:0]   instr_pc,
  output logic [31:0]   pc_plus4,
  output logic          instr_valid,
  output logic          fetch_halt,
  output logic          addr_err,
  output logic          bus_err
);
  import mips_pkg::*;

  fetch_state_t state_reg;

  logic out_free;
  logic aligned;
  logic advance;
  logic wait_inc;
  logic wait_clr;
  logic timeout_hit;

  // The output register can take a new word when empty or being consumed.
  assign out_free      = !instr_valid || !decode_stall;
  assign aligned       = (pc[1:0] == 2'b00);
  assign imem.imem_req  = (state_reg == REQ) && out_free && aligned && !flush;
  assign imem.imem_addr = pc;
  assign advance       = imem.imem_req && imem.imem_ready;
  // ERR freezes the PC for good, even against a redirect.
  assign fetch_halt    = (state_reg == ERR) ? 1'b1 : !(advance || flush);

  assign wait_inc = imem.imem_req && !imem.imem_ready;
  assign wait_clr = (state_reg != REQ) || flush || advance;

  fetch_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clock_pc (clock_pc),
    .reset    (reset),
    .inc      (wait_inc),
    .clr      (wait_clr),
    .hit      (timeout_hit)
  );

  always_ff @(posedge clock_pc or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      instr       <= NOP;
      instr_pc    <= RESET_VECTOR;
      pc_plus4    <= RESET_VECTOR;
      instr_valid <= 1'b0;
      addr_err    <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          // A redirect arriving here restarts the one-cycle bubble.
          if (flush) begin
            state_reg   <= IDLE;
            instr_valid <= 1'b0;
            instr       <= NOP;
          end else begin
            state_reg <= REQ;
          end
        end

        REQ: begin
          if (flush) begin
            state_reg   <= IDLE;
            instr_valid <= 1'b0;
            instr       <= NOP;
          end else if (!aligned) begin
            state_reg <= ERR;
            addr_err  <= 1'b1;
          end else if (advance) begin
            instr       <= imem.imem_rdata;
            instr_pc    <= pc;
            pc_plus4    <= pc + 32'(INSTR_BYTES);
            instr_valid <= 1'b1;
          end else begin
            if (wait_inc && timeout_hit) begin
              state_reg <= ERR;
              bus_err   <= 1'b1;
            end
            // Decode took the word without a refill landing behind it, so it
            // must not be presented a second time.
            if (instr_valid && !decode_stall) begin
              instr_valid <= 1'b0;
            end
          end
        end

        ERR: begin
          instr_valid <= 1'b0;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = 32'h0;
  logic        ready = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic        flush = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] instr, instr_pc, pc_plus4;
  logic        instr_valid, fetch_halt, addr_err, bus_err;

  logic        reset2 = 1'b1;
  logic [31:0] pc2 = 32'h0;
  logic        ready2 = 1'b0;
  logic [31:0] rdata2 = 32'h0;
  logic [31:0] instr2, instr_pc2, pc_plus4_2;
  logic        instr_valid2, fetch_halt2, addr_err2, bus_err2;

  int checks = 0;
  int errors = 0;

  logic [95:0] sb[$];
  logic        hs_prev = 1'b0;

  always #5 clk = ~clk;

  fetch_stage_if bus1();
  fetch_stage_if bus2();

  assign bus1.imem_ready = ready;
  assign bus1.imem_rdata = rdata;
  assign bus2.imem_ready = ready2;
  assign bus2.imem_rdata = rdata2;

  fetch_stage #(.TIMEOUT(255), .NOP(32'h0)) dut (
    .clock_pc(clk), .reset(reset), .pc(pc), .flush(flush), .decode_stall(stall),
    .imem(bus1.master), .instr(instr), .instr_pc(instr_pc), .pc_plus4(pc_plus4),
    .instr_valid(instr_valid), .fetch_halt(fetch_halt), .addr_err(addr_err), .bus_err(bus_err)
  );

  fetch_stage #(.TIMEOUT(4), .NOP(32'h0)) dut_t (
    .clock_pc(clk), .reset(reset2), .pc(pc2), .flush(1'b0), .decode_stall(1'b0),
    .imem(bus2.master), .instr(instr2), .instr_pc(instr_pc2), .pc_plus4(pc_plus4_2),
    .instr_valid(instr_valid2), .fetch_halt(fetch_halt2), .addr_err(addr_err2), .bus_err(bus_err2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  // Scoreboard monitor: a handshake in one cycle must show up in the
  // IF/ID register by the next falling edge.
  always @(negedge clk) begin
    logic [95:0] e;
    if (hs_prev) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_fetch actual=instr %h pc %h expected=no fetch", instr, instr_pc);
      end else begin
        e = sb.pop_front();
        chk("sb instr", instr, e[95:64]);
        chk("sb instr_pc", instr_pc, e[63:32]);
        chk("sb pc_plus4", pc_plus4, e[31:0]);
        chk("sb instr_valid", {31'b0, instr_valid}, 32'd1);
      end
    end
    hs_prev = bus1.imem_req && bus1.imem_ready && !reset;
  end

  task automatic cyc(input string tag, input logic [31:0] p, input logic r,
                     input logic [31:0] d, input logic f, input logic s,
                     input logic e_req, input logic e_halt);
    pc = p; ready = r; rdata = d; flush = f; stall = s;
    @(negedge clk);
    chk({tag, " imem_req"}, {31'b0, bus1.imem_req}, {31'b0, e_req});
    chk({tag, " fetch_halt"}, {31'b0, fetch_halt}, {31'b0, e_halt});
    chk({tag, " imem_addr"}, bus1.imem_addr, p);
    if (e_req && r) sb.push_back({d, p, p + 32'd4});
    @(posedge clk); #1;
  endtask

  task automatic cyc2(input string tag, input logic r, input logic [31:0] d,
                      input logic e_req, input logic e_halt);
    ready2 = r; rdata2 = d;
    @(negedge clk);
    chk({tag, " imem_req"}, {31'b0, bus2.imem_req}, {31'b0, e_req});
    chk({tag, " fetch_halt"}, {31'b0, fetch_halt2}, {31'b0, e_halt});
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pc = 32'h0; ready = 1'b1; rdata = 32'h2008_0005;
    repeat (2) begin @(posedge clk); #1; end
    chk("reset instr", instr, 32'h0);
    chk("reset instr_pc", instr_pc, 32'h0);
    chk("reset pc_plus4", pc_plus4, 32'h0);
    chk("reset valid", {31'b0, instr_valid}, 32'd0);
    chk("reset errs", {30'b0, addr_err, bus_err}, 32'd0);
    chk("reset imem_req", {31'b0, bus1.imem_req}, 32'd0);
    reset = 1'b0;

    // First fetch after reset: one IDLE cycle, request on cycle 2.
    cyc("c1 idle",  32'h0, 1'b1, 32'h2008_0005, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("c2 fetch", 32'h0, 1'b1, 32'h2008_0005, 1'b0, 1'b0, 1'b1, 1'b0);

    // Decode stall holds the output and blocks the next request.
    cyc("c3 stall", 32'h4, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("c3 hold instr", instr, 32'h2008_0005);
    chk("c3 hold instr_pc", instr_pc, 32'h0);
    cyc("c4 stall", 32'h4, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("c4 hold instr", instr, 32'h2008_0005);
    chk("c4 hold pc_plus4", pc_plus4, 32'h4);
    cyc("c5 release", 32'h4, 1'b1, 32'h8C09_0000, 1'b0, 1'b0, 1'b1, 1'b0);

    // Memory not ready for three cycles at pc=8.
    cyc("c6 wait", 32'h8, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc("c7 wait", 32'h8, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc("c8 wait", 32'h8, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc("c9 fetch", 32'h8, 1'b1, 32'h012A_5820, 1'b0, 1'b0, 1'b1, 1'b0);

    // Flush while waiting; ready in the flush cycle is ignored.
    cyc("c10 wait", 32'hC, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc("c11 flush", 32'hC, 1'b1, 32'h1111_1111, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("c11 flush valid", {31'b0, instr_valid}, 32'd0);
    chk("c11 flush instr", instr, 32'h0);
    cyc("c12 idle", 32'h40, 1'b1, 32'h1000_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("c13 fetch", 32'h40, 1'b1, 32'h1000_FFFF, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("c14 b2b", 32'h44, 1'b1, 32'hAC0B_0004, 1'b0, 1'b0, 1'b1, 1'b0);

    // Misaligned pc: no request, terminal error, flush ignored afterwards.
    cyc("c15 misalign", 32'h6, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("c15 addr_err", {31'b0, addr_err}, 32'd1);
    cyc("c16 err flush", 32'h40, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc("c17 err", 32'h40, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("c17 valid", {31'b0, instr_valid}, 32'd0);
    chk("c17 addr_err", {31'b0, addr_err}, 32'd1);
    chk("c17 bus_err", {31'b0, bus_err}, 32'd0);

    // Asynchronous reset clears everything without a clock edge.
    #1 reset = 1'b1;
    #1;
    chk("async addr_err", {31'b0, addr_err}, 32'd0);
    chk("async instr_pc", instr_pc, 32'h0);
    chk("async pc_plus4", pc_plus4, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    cyc("r1 idle", 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    pc = 32'h100; ready = 1'b0;
    #1;
    chk("r2 imem_req pre", {31'b0, bus1.imem_req}, 32'd1);
    reset = 1'b1;
    #1;
    chk("r2 imem_req reset", {31'b0, bus1.imem_req}, 32'd0);
    @(posedge clk); #1;

    // Timeout instance: TIMEOUT=4.
    reset2 = 1'b0;
    cyc2("t1 idle", 1'b0, 32'h0, 1'b0, 1'b1);
    cyc2("t2 wait", 1'b0, 32'h0, 1'b1, 1'b1);
    cyc2("t3 wait", 1'b0, 32'h0, 1'b1, 1'b1);
    cyc2("t4 wait", 1'b0, 32'h0, 1'b1, 1'b1);
    cyc2("t5 fetch", 1'b1, 32'hAAAA_5555, 1'b1, 1'b0);
    chk("t5 instr", instr2, 32'hAAAA_5555);
    chk("t5 bus_err", {31'b0, bus_err2}, 32'd0);
    cyc2("t6 wait", 1'b0, 32'h0, 1'b1, 1'b1);
    cyc2("t7 wait", 1'b0, 32'h0, 1'b1, 1'b1);
    cyc2("t8 wait", 1'b0, 32'h0, 1'b1, 1'b1);
    chk("t8 bus_err", {31'b0, bus_err2}, 32'd0);
    cyc2("t9 wait", 1'b0, 32'h0, 1'b1, 1'b1);
    chk("t9 bus_err", {31'b0, bus_err2}, 32'd1);
    cyc2("t10 err", 1'b1, 32'h0, 1'b0, 1'b1);
    chk("t10 bus_err", {31'b0, bus_err2}, 32'd1);
    reset2 = 1'b1;
    #1;
    chk("t reset bus_err", {31'b0, bus_err2}, 32'd0);

    @(posedge clk); #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover actual=%0d expected=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
